// File: rtl/if_wb_master_pkg.sv
// if_wb_master_pkg: FSM encodings and CPU-wide control constants for the fetch bus master.
package if_wb_master_pkg;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] WAIT_STALL = 2'b10;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam logic Flush = 1'b1;
    localparam logic NoFlush = 1'b0;
    localparam logic [3:0] SelWord = 4'b1111;
endpackage

// File: rtl/if_wb_master.sv
// if_wb_master: instruction-fetch Wishbone B4 classic master with flush abort and ack timeout.
module if_wb_master
    import if_wb_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [1:0] state;
    logic [DATA_W-1:0] rd_buf;
    logic [CW-1:0] cnt;
    logic cyc;
    logic timeout;
    assign timeout = (TIMEOUT != 0) && (cnt == LAST);
    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign wb_we_o = 1'b0;
    assign wb_sel_o = cyc ? SelWord : 4'b0000;
    always_comb begin
        stallreq_o = state == IDLE ? cpu_ce_i & ~flush_i :
                     state == BUSY ? ~wb_ack_i & ~flush_i : 1'b0;
        cpu_data_o = state == BUSY ? (wb_ack_i ? wb_data_i : DATA_W'(ZeroWord)) : rd_buf;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cyc <= 1'b0;
            wb_addr_o <= '0;
            rd_buf <= '0;
            cnt <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: if (cpu_ce_i && !flush_i) begin
                    wb_addr_o <= cpu_addr_i;
                    cyc <= 1'b1;
                    cnt <= '0;
                    state <= BUSY;
                end
                BUSY: if (flush_i) begin
                    cyc <= 1'b0;
                    rd_buf <= '0;
                    state <= IDLE;
                end else if (wb_ack_i) begin
                    cyc <= 1'b0;
                    rd_buf <= wb_data_i;
                    state <= stall_i != 6'd0 ? WAIT_STALL : IDLE;
                end else if (timeout) begin
                    // hung slave: retire the fetch as a NOP and flag it
                    cyc <= 1'b0;
                    rd_buf <= '0;
                    bus_err_o <= 1'b1;
                    state <= IDLE;
                end else begin
                    cnt <= cnt == '1 ? cnt : cnt + 1'b1;
                end
                WAIT_STALL: begin
                    if (flush_i) rd_buf <= '0;
                    if (flush_i || stall_i == 6'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_wb_master.sv
// tb_if_wb_master: directed checks of fetch, stall hold, flush, timeout, reset abort and back-to-back reads.
module tb_if_wb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_ce_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [5:0] stall_i = '0;
    logic flush_i = 1'b0;
    logic [31:0] cpu_data_o;
    logic stallreq_o;
    logic bus_err_o;
    logic [31:0] wb_data_i = '0;
    logic wb_ack_i = 1'b0;
    logic [31:0] wb_addr_o;
    logic wb_cyc_o;
    logic wb_stb_o;
    logic wb_we_o;
    logic [3:0] wb_sel_o;
    int checks = 0;
    int errors = 0;
    int cyc_rises = 0;
    logic [31:0] addrs [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] words [3] = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003};

    if_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
        .stall_i(stall_i), .flush_i(flush_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i), .wb_addr_o(wb_addr_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
    );

    always #5 clk = ~clk;
    always @(posedge wb_cyc_o) cyc_rises++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return a == 32'h100 ? 32'h2001_0001 : a == 32'h104 ? 32'h2002_0002 :
               a == 32'h108 ? 32'h2003_0003 : 32'hBAD0_BAD0;
    endfunction

    initial begin
        tick();
        tick();
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_data", cpu_data_o, 0);
        rst = 1'b0;
        // 1: single fetch, ack in the first strobe cycle
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h4;
        #1 chk("t1_req_stall", stallreq_o, 1);
        tick();
        cpu_ce_i = 1'b0;
        chk("t1_addr", wb_addr_o, 32'h4);
        chk("t1_sel", wb_sel_o, 4'hF);
        chk("t1_cyc", wb_cyc_o, 1);
        chk("t1_busy_stall", stallreq_o, 1);
        chk("t1_busy_data", cpu_data_o, 0);
        wb_ack_i = 1'b1;
        wb_data_i = 32'h3401_0020;
        #1 chk("t1_fwd", cpu_data_o, 32'h3401_0020);
        chk("t1_ack_stall", stallreq_o, 0);
        tick();
        wb_ack_i = 1'b0;
        chk("t1_cyc_drop", wb_cyc_o, 0);
        chk("t1_hold", cpu_data_o, 32'h3401_0020);
        // 2: ack while the pipeline is stalled
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h8;
        tick();
        cpu_ce_i = 1'b0;
        stall_i = 6'b000011;
        wb_ack_i = 1'b1;
        wb_data_i = 32'hDEAD_BEEF;
        #1 chk("t2_fwd", cpu_data_o, 32'hDEAD_BEEF);
        tick();
        wb_ack_i = 1'b0;
        wb_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_state", dut.state, 2'b10);
            chk("t2_data", cpu_data_o, 32'hDEAD_BEEF);
            chk("t2_stallreq", stallreq_o, 0);
            chk("t2_cyc", wb_cyc_o, 0);
            if (i < 2) tick();
        end
        stall_i = 6'b0;
        tick();
        chk("t2_idle", dut.state, 2'b00);
        chk("t2_keep", cpu_data_o, 32'hDEAD_BEEF);
        // 3: flush in second busy cycle, then a late ack
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'hC;
        tick();
        cpu_ce_i = 1'b0;
        tick();
        chk("t3_cyc_busy", wb_cyc_o, 1);
        flush_i = 1'b1;
        #1 chk("t3_flush_stall", stallreq_o, 0);
        tick();
        flush_i = 1'b0;
        chk("t3_cyc", wb_cyc_o, 0);
        chk("t3_stb", wb_stb_o, 0);
        wb_ack_i = 1'b1;
        wb_data_i = 32'h1234_5678;
        #1 chk("t3_late_data", cpu_data_o, 0);
        tick();
        wb_ack_i = 1'b0;
        chk("t3_not_latched", cpu_data_o, 0);
        chk("t3_no_err", bus_err_o, 0);
        // 4: slave never acks; TIMEOUT=4 gives four strobe cycles
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h10;
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_cyc_held", wb_cyc_o, 1);
            chk("t4_err_low", bus_err_o, 0);
            tick();
        end
        chk("t4_cyc_drop", wb_cyc_o, 0);
        chk("t4_err", bus_err_o, 1);
        chk("t4_data", cpu_data_o, 0);
        tick();
        chk("t4_err_pulse", bus_err_o, 0);
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h14;
        tick();
        cpu_ce_i = 1'b0;
        chk("t4_next_addr", wb_addr_o, 32'h14);
        chk("t4_next_cyc", wb_cyc_o, 1);
        wb_ack_i = 1'b1;
        wb_data_i = 32'h0000_A5A5;
        #1 chk("t4_next_data", cpu_data_o, 32'h0000_A5A5);
        tick();
        wb_ack_i = 1'b0;
        // 5: reset during busy cycle 2
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h20;
        tick();
        cpu_ce_i = 1'b0;
        tick();
        chk("t5_cyc_busy", wb_cyc_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cyc", wb_cyc_o, 0);
        chk("t5_stb", wb_stb_o, 0);
        chk("t5_sel", wb_sel_o, 0);
        chk("t5_addr", wb_addr_o, 0);
        chk("t5_err", bus_err_o, 0);
        chk("t5_data", cpu_data_o, 0);
        tick();
        chk("t5_err_after", bus_err_o, 0);
        // 6: back-to-back fetches with a zero-wait slave; PC moves while busy
        cyc_rises = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_ce_i = 1'b1;
            cpu_addr_i = addrs[i];
            tick();
            cpu_addr_i = 32'hFFFF_FFF0;
            #1 chk("t6_addr", wb_addr_o, addrs[i]);
            chk("t6_cyc", wb_cyc_o, 1);
            wb_ack_i = 1'b1;
            wb_data_i = slave_word(wb_addr_o);
            #1 chk("t6_fwd", cpu_data_o, words[i]);
            tick();
            wb_ack_i = 1'b0;
            chk("t6_gap", wb_cyc_o, 0);
            chk("t6_word", cpu_data_o, words[i]);
        end
        cpu_ce_i = 1'b0;
        chk("t6_rises", cyc_rises, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
